light_dir_sched: RTL and testbench

Sequencer that time-shares one light-direction subtraction datapath across up to NUM_LIGHTS configured point lights. For each accepted surface point it emits one direction vector (light − surface) per enabled light, in ascending light index, over a valid/ready stream. It sits between the surface-point generator and the per-light shading stage.

---
 rtl/light_dir_sched.sv | 173 +++++++++++++++++
 tb/tb_light_dir_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/light_dir_sched.sv
// Light-direction sequencer: for each accepted surface point, streams one
// (light - surface) vector per enabled light slot in ascending slot order.
module light_dir_sched #(
  parameter int NUM_LIGHTS = 4,
  parameter int W          = 16,
  parameter int IW         = $clog2(NUM_LIGHTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [W-1:0]  cfg_x,
  input  logic [W-1:0]  cfg_y,
  input  logic [W-1:0]  cfg_z,
  input  logic          cfg_en,
  output logic          cfg_ready,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_x,
  input  logic [W-1:0]  s_y,
  input  logic [W-1:0]  s_z,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_dir_x,
  output logic [W-1:0]  m_dir_y,
  output logic [W-1:0]  m_dir_z,
  output logic [IW-1:0] m_light_idx,
  output logic          m_last,
  output logic          busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_r;
  logic [W-1:0]          light_x_r [NUM_LIGHTS];
  logic [W-1:0]          light_y_r [NUM_LIGHTS];
  logic [W-1:0]          light_z_r [NUM_LIGHTS];
  logic [NUM_LIGHTS-1:0] mask_r;
  logic [NUM_LIGHTS-1:0] act_mask_r;
  logic [W-1:0]          surf_x_r;
  logic [W-1:0]          surf_y_r;
  logic [W-1:0]          surf_z_r;
  logic                  m_valid_r;
  logic [W-1:0]          m_dir_x_r;
  logic [W-1:0]          m_dir_y_r;
  logic [W-1:0]          m_dir_z_r;
  logic [IW-1:0]         m_light_idx_r;
  logic                  m_last_r;
  logic                  busy_s;
  logic                  s_ready_s;
  logic                  cfg_ok_s;
  logic [IW-1:0]         first_idx_s;
  logic [IW-1:0]         next_idx_s;

  // Lowest set bit of m at or above position start (0 when none).
  function automatic logic [IW-1:0] first_set_from(input logic [NUM_LIGHTS-1:0] m,
                                                   input int start);
    logic [IW-1:0] r;
    logic          found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      if (!found && (i >= start) && m[i]) begin
        r     = IW'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // True when no bit of m lies above position i.
  function automatic logic is_highest(input logic [NUM_LIGHTS-1:0] m,
                                      input logic [IW-1:0] i);
    logic hi;
    hi = 1'b1;
    for (int j = 0; j < NUM_LIGHTS; j++) begin
      if ((j > int'(i)) && m[j]) begin
        hi = 1'b0;
      end
    end
    return hi;
  endfunction

  // Handshake qualifiers and slot selection for the next beat.
  always_comb begin
    busy_s      = (state_r == ISSUE);
    s_ready_s   = !busy_s && (mask_r != '0);
    cfg_ok_s    = cfg_we && !busy_s && (32'(cfg_idx) < NUM_LIGHTS);
    first_idx_s = first_set_from(mask_r, 32'sd0);
    next_idx_s  = first_set_from(act_mask_r, int'(m_light_idx_r) + 32'sd1);
  end

  // Light position and enable storage; writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LIGHTS; i++) begin
        light_x_r[i] <= '0;
        light_y_r[i] <= '0;
        light_z_r[i] <= '0;
      end
      mask_r <= '0;
    end else if (cfg_ok_s) begin
      light_x_r[cfg_idx] <= cfg_x;
      light_y_r[cfg_idx] <= cfg_y;
      light_z_r[cfg_idx] <= cfg_z;
      mask_r[cfg_idx]    <= cfg_en;
    end
  end

  // Issue FSM; m_light_idx_r doubles as the current slot pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      act_mask_r    <= '0;
      surf_x_r      <= '0;
      surf_y_r      <= '0;
      surf_z_r      <= '0;
      m_valid_r     <= 1'b0;
      m_dir_x_r     <= '0;
      m_dir_y_r     <= '0;
      m_dir_z_r     <= '0;
      m_light_idx_r <= '0;
      m_last_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (s_valid && s_ready_s) begin
            surf_x_r      <= s_x;
            surf_y_r      <= s_y;
            surf_z_r      <= s_z;
            act_mask_r    <= mask_r;
            m_valid_r     <= 1'b1;
            m_dir_x_r     <= light_x_r[first_idx_s] - s_x;
            m_dir_y_r     <= light_y_r[first_idx_s] - s_y;
            m_dir_z_r     <= light_z_r[first_idx_s] - s_z;
            m_light_idx_r <= first_idx_s;
            m_last_r      <= is_highest(mask_r, first_idx_s);
            state_r       <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            if (m_last_r) begin
              m_valid_r <= 1'b0;
              state_r   <= IDLE;
            end else begin
              m_dir_x_r     <= light_x_r[next_idx_s] - surf_x_r;
              m_dir_y_r     <= light_y_r[next_idx_s] - surf_y_r;
              m_dir_z_r     <= light_z_r[next_idx_s] - surf_z_r;
              m_light_idx_r <= next_idx_s;
              m_last_r      <= is_highest(act_mask_r, next_idx_s);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          m_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_s;
  assign cfg_ready   = !busy_s;
  assign s_ready     = s_ready_s;
  assign m_valid     = m_valid_r;
  assign m_dir_x     = m_dir_x_r;
  assign m_dir_y     = m_dir_y_r;
  assign m_dir_z     = m_dir_z_r;
  assign m_light_idx = m_light_idx_r;
  assign m_last      = m_last_r;

endmodule

// File: tb/tb_light_dir_sched.sv
// Directed bench for light_dir_sched: a light-table model pushes expected beats
// to a queue, and a monitor pops and compares every output handshake.
module tb_light_dir_sched;
  localparam int NL = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic clk, reset, cfg_we, cfg_en, cfg_ready, s_valid, s_ready;
  logic m_valid, m_ready, m_last, busy;
  logic [IW-1:0] cfg_idx, m_light_idx;
  logic [W-1:0]  cfg_x, cfg_y, cfg_z, s_x, s_y, s_z, m_dir_x, m_dir_y, m_dir_z;

  beat_t        exp_q [$];
  logic [W-1:0] lx [NL];
  logic [W-1:0] ly [NL];
  logic [W-1:0] lz [NL];
  logic [NL-1:0] men;
  int n_checks = 0;
  int n_fail   = 0;

  light_dir_sched #(.NUM_LIGHTS(NL), .W(W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z), .cfg_en(cfg_en),
    .cfg_ready(cfg_ready), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_z(s_z), .m_valid(m_valid), .m_ready(m_ready),
    .m_dir_x(m_dir_x), .m_dir_y(m_dir_y), .m_dir_z(m_dir_z),
    .m_light_idx(m_light_idx), .m_last(m_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      beat_t obs;
      obs = {m_dir_x, m_dir_y, m_dir_z, m_light_idx, m_last};
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed %h expected none", obs);
      end
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        n_checks++;
        assert (obs === e) else begin
          n_fail++;
          $error("FAIL beat: observed %h expected %h", obs, e);
        end
      end
    end
  end

  task automatic cfg_write(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] z, input logic en, input logic model_upd);
    cfg_we = 1'b1; cfg_idx = IW'(i); cfg_x = x; cfg_y = y; cfg_z = z; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (model_upd) begin
      lx[i] = x; ly[i] = y; lz[i] = z; men[i] = en;
    end
  endtask

  task automatic send_point(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    logic ok;
    int last_i;
    beat_t b;
    last_i = -1;
    for (int i = 0; i < NL; i++) if (men[i]) last_i = i;
    for (int i = 0; i < NL; i++) begin
      if (men[i]) begin
        b.x = lx[i] - x; b.y = ly[i] - y; b.z = lz[i] - z;
        b.idx = IW'(i); b.last = (i == last_i);
        exp_q.push_back(b);
      end
    end
    s_valid = 1'b1; s_x = x; s_y = y; s_z = z;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50 && busy; c++) @(posedge clk);
    #1;
    check("idle_bound", 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_z = '0;
    cfg_en = 1'b0; s_valid = 1'b0; s_x = '0; s_y = '0; s_z = '0; m_ready = 1'b1;
    men = '0;
    for (int i = 0; i < NL; i++) begin lx[i] = '0; ly[i] = '0; lz[i] = '0; end
    repeat (2) @(posedge clk); #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_dir", {16'd0, m_dir_x, m_dir_y, m_dir_z}, 64'd0);
    check("rst_idx_last", {m_light_idx, m_last}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    reset = 1'b0;

    // Empty mask: a waiting point must not be accepted.
    s_valid = 1'b1; s_x = 16'd1; s_y = 16'd1; s_z = 16'd1;
    repeat (3) begin
      @(negedge clk);
      check("empty_mask_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    cfg_write(0, 16'd100, 16'd200, 16'd300, 1'b1, 1'b1);
    check("enable_raises_s_ready", 64'(s_ready), 64'd1);

    // Single light.
    send_point(16'd10, 16'd20, 16'd30);
    check("single_beat", {m_valid, m_dir_x, m_dir_y, m_dir_z, m_light_idx, m_last},
          {1'b1, 16'd90, 16'd180, 16'd270, 2'd0, 1'b1});
    check("single_busy_s_ready", {busy, s_ready}, {1'b1, 1'b0});
    @(posedge clk); #1;
    check("single_done", {m_valid, busy, s_ready}, {1'b0, 1'b0, 1'b1});

    // Sparse mask, negative wrap on slot 3.
    cfg_write(0, 16'd100, 16'd200, 16'd300, 1'b0, 1'b1);
    cfg_write(1, 16'd5, 16'd5, 16'd5, 1'b1, 1'b1);
    cfg_write(3, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1);
    send_point(16'd1, 16'd2, 16'd3);
    check("sparse_b0", {m_dir_x, m_dir_y, m_dir_z, m_light_idx, m_last},
          {16'd4, 16'd3, 16'd2, 2'd1, 1'b0});
    @(posedge clk); #1;
    check("sparse_b1", {m_dir_x, m_dir_y, m_dir_z, m_light_idx, m_last},
          {16'hFFFF, 16'hFFFE, 16'hFFFD, 2'd3, 1'b1});
    @(posedge clk); #1;
    check("sparse_done", 64'(m_valid), 64'd0);

    // Backpressure on the second of four beats.
    cfg_write(0, 16'd100, 16'd200, 16'd300, 1'b1, 1'b1);
    cfg_write(2, 16'd7, 16'd8, 16'd9, 1'b1, 1'b1);
    send_point(16'd10, 16'd20, 16'd30);
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold", {m_valid, m_dir_x, m_dir_y, m_dir_z, m_light_idx, m_last, s_ready},
            {1'b1, 16'hFFFB, 16'hFFF1, 16'hFFE7, 2'd1, 1'b0, 1'b0});
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_b2", {m_light_idx, m_last, s_ready}, {2'd2, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("bp_b3", {m_light_idx, m_last, s_ready}, {2'd3, 1'b1, 1'b0});
    @(posedge clk); #1;
    check("bp_done", {m_valid, s_ready}, {1'b0, 1'b1});

    // Config write while busy is dropped; the same write while idle lands.
    send_point(16'd0, 16'd0, 16'd0);
    check("blocked_cfg_ready", 64'(cfg_ready), 64'd0);
    cfg_write(0, 16'd1, 16'd1, 16'd1, 1'b1, 1'b0);
    wait_idle();
    send_point(16'd0, 16'd0, 16'd0);
    check("old_pos_used", 64'(m_dir_x), 64'd100);
    wait_idle();
    cfg_write(0, 16'd1, 16'd1, 16'd1, 1'b1, 1'b1);
    send_point(16'd0, 16'd0, 16'd0);
    check("new_pos_used", 64'(m_dir_x), 64'd1);
    wait_idle();

    // Reset during the second of three beats.
    cfg_write(3, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
    send_point(16'd10, 16'd10, 16'd10);
    @(posedge clk); #1;
    check("mid_idx", 64'(m_light_idx), 64'd1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    men = '0;
    check("mid_rst_outputs", {m_valid, m_dir_x, m_dir_y, m_dir_z, m_light_idx, m_last},
          64'd0);
    check("mid_rst_ctrl", {busy, cfg_ready, s_ready}, {1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0;
    s_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_s_ready", {s_ready, m_valid}, 64'd0);
    end
    s_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
